// File: rtl/bus_step_sequencer_pkg.sv
// Shared definitions for the single-bus control-step sequencer: step
// encoding and the bus-mux select codes used by both the sequencer and the mux.
package bus_step_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_T0   = 3'd1,
    ST_T1   = 3'd2,
    ST_T2   = 3'd3,
    ST_T3   = 3'd4,
    ST_T4   = 3'd5,
    ST_T5   = 3'd6,
    ST_T6   = 3'd7
  } state_e;

  localparam logic [4:0] BUS_SEL_NONE    = 5'd0;
  localparam logic [4:0] BUS_SEL_R0_BASE = 5'd1;
  localparam logic [4:0] BUS_SEL_HI      = 5'd17;
  localparam logic [4:0] BUS_SEL_LO      = 5'd18;
  localparam logic [4:0] BUS_SEL_ZHI     = 5'd19;
  localparam logic [4:0] BUS_SEL_ZLO     = 5'd20;
  localparam logic [4:0] BUS_SEL_PC      = 5'd21;
  localparam logic [4:0] BUS_SEL_MDR     = 5'd22;
  localparam logic [4:0] BUS_SEL_INPORT  = 5'd23;
  localparam logic [4:0] BUS_SEL_CSIGN   = 5'd24;

  // Bus select code that puts general register idx on the bus.
  function automatic logic [4:0] bus_sel_reg(input logic [3:0] idx);
    return BUS_SEL_R0_BASE + {1'b0, idx};
  endfunction

endpackage

// File: rtl/bus_step_sequencer_reg_index_decoder.sv
// 4-bit register index to 16-bit one-hot load strobe; all zero when disabled.
// Shared with the register-file write port so both agree on the index mapping.
module reg_index_decoder (
  input  logic        en,
  input  logic [3:0]  idx,
  output logic [15:0] onehot
);

  // One-hot decode of idx, gated by en.
  always_comb begin
    onehot = 16'h0000;
    if (en) begin
      onehot[idx] = 1'b1;
    end else begin
      onehot = 16'h0000;
    end
  end

endmodule

// File: rtl/bus_step_sequencer.sv
// Control-step sequencer for the 32-bit single-bus datapath. Fetches an
// instruction (T0..T2) and runs one register-to-register ALU op (T3..T6),
// driving the bus-mux select and every register load strobe each cycle.
module bus_step_sequencer
  import bus_step_sequencer_pkg::*;
#(
  parameter int MEM_TIMEOUT = 15,
  parameter int SEL_W       = 5
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             start,
  input  logic             mem_ready,
  input  logic             muldiv,
  input  logic [3:0]       ra,
  input  logic [3:0]       rb,
  input  logic [3:0]       rc,
  output logic [SEL_W-1:0] bus_sel,
  output logic [15:0]      reg_in,
  output logic             pc_in,
  output logic             mar_in,
  output logic             mdr_in,
  output logic             ir_in,
  output logic             y_in,
  output logic             z_in,
  output logic             hi_in,
  output logic             lo_in,
  output logic             inc_pc,
  output logic             mem_read,
  output logic             alu_go,
  output logic             busy,
  output logic             done,
  output logic             err
);

  localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);

  state_e           state_q, state_d;
  logic [3:0]       ra_q, ra_d;
  logic [3:0]       rb_q, rb_d;
  logic [3:0]       rc_q, rc_d;
  logic             muldiv_q, muldiv_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             timeout_s;
  logic             t1_first_s;
  logic             wr_en_s;
  logic [4:0]       sel_s;

  // The memory wait has run out once the counter holds MEM_TIMEOUT while in T1.
  assign timeout_s  = (state_q == ST_T1) && (cnt_q == CNT_W'(MEM_TIMEOUT));
  // The counter only advances on wait cycles, so zero in T1 means first T1 cycle.
  assign t1_first_s = (state_q == ST_T1) && (cnt_q == {CNT_W{1'b0}});
  // Writeback to the general register file happens only for non-muldiv T5.
  assign wr_en_s    = (state_q == ST_T5) && !muldiv_q;

  assign bus_sel = SEL_W'(sel_s);

  reg_index_decoder u_wr_decode (
    .en     (wr_en_s),
    .idx    (ra_q),
    .onehot (reg_in)
  );

  // State, latched operands and memory-wait counter.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      ra_q     <= 4'd0;
      rb_q     <= 4'd0;
      rc_q     <= 4'd0;
      muldiv_q <= 1'b0;
      cnt_q    <= {CNT_W{1'b0}};
    end else begin
      state_q  <= state_d;
      ra_q     <= ra_d;
      rb_q     <= rb_d;
      rc_q     <= rc_d;
      muldiv_q <= muldiv_d;
      cnt_q    <= cnt_d;
    end
  end

  // Step sequencing, operand capture on T2->T3 and memory-wait counting.
  always_comb begin
    state_d  = state_q;
    ra_d     = ra_q;
    rb_d     = rb_q;
    rc_d     = rc_q;
    muldiv_d = muldiv_q;
    cnt_d    = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_T0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_T0: state_d = ST_T1;
      ST_T1: begin
        if (timeout_s) begin
          state_d = ST_IDLE;
          cnt_d   = {CNT_W{1'b0}};
        end else if (mem_ready) begin
          state_d = ST_T2;
          cnt_d   = {CNT_W{1'b0}};
        end else begin
          cnt_d   = cnt_q + CNT_W'(1);
        end
      end
      ST_T2: begin
        state_d  = ST_T3;
        ra_d     = ra;
        rb_d     = rb;
        rc_d     = rc;
        muldiv_d = muldiv;
      end
      ST_T3: state_d = ST_T4;
      ST_T4: state_d = ST_T5;
      ST_T5: begin
        if (muldiv_q) begin
          state_d = ST_T6;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_T6:   state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Moore decode of bus select and strobes; T1 also looks at mem_ready/timeout.
  always_comb begin
    sel_s    = BUS_SEL_NONE;
    pc_in    = 1'b0;
    mar_in   = 1'b0;
    mdr_in   = 1'b0;
    ir_in    = 1'b0;
    y_in     = 1'b0;
    z_in     = 1'b0;
    hi_in    = 1'b0;
    lo_in    = 1'b0;
    inc_pc   = 1'b0;
    mem_read = 1'b0;
    alu_go   = 1'b0;
    done     = 1'b0;
    err      = 1'b0;
    busy     = (state_q != ST_IDLE);
    case (state_q)
      ST_IDLE: sel_s = BUS_SEL_NONE;
      ST_T0: begin
        sel_s  = BUS_SEL_PC;
        mar_in = 1'b1;
        inc_pc = 1'b1;
        z_in   = 1'b1;
      end
      ST_T1: begin
        sel_s    = BUS_SEL_ZLO;
        mem_read = 1'b1;
        pc_in    = t1_first_s;
        if (timeout_s) begin
          err    = 1'b1;
        end else if (mem_ready) begin
          mdr_in = 1'b1;
        end else begin
          mdr_in = 1'b0;
        end
      end
      ST_T2: begin
        sel_s = BUS_SEL_MDR;
        ir_in = 1'b1;
      end
      ST_T3: begin
        sel_s = bus_sel_reg(rb_q);
        y_in  = 1'b1;
      end
      ST_T4: begin
        sel_s  = bus_sel_reg(rc_q);
        alu_go = 1'b1;
        z_in   = 1'b1;
      end
      ST_T5: begin
        sel_s = BUS_SEL_ZLO;
        if (muldiv_q) begin
          lo_in = 1'b1;
        end else begin
          done  = 1'b1;
        end
      end
      ST_T6: begin
        sel_s = BUS_SEL_ZHI;
        hi_in = 1'b1;
        done  = 1'b1;
      end
      default: sel_s = BUS_SEL_NONE;
    endcase
  end

endmodule

// File: doc/bus_step_sequencer.md
Name: bus_step_sequencer

Overview:
- Control-step FSM for the 32-bit single-bus datapath: fetches an instruction, then runs a register-to-register ALU operation over steps T0..T6.
- Each cycle it drives the 5-bit bus-mux select code plus all register load strobes; it is the only driver of the bus select.
- Sits between the instruction decoder (which supplies ra/rb/rc and the op class) and the datapath register file, ALU, Y/Z, HI/LO, PC, MAR and MDR.

Parameters:
- MEM_TIMEOUT, 15: maximum cycles to wait in T1 for mem_ready before aborting; counter width is clog2(MEM_TIMEOUT+1).
- SEL_W, 5: bus select width.

Ports:
- clock  in  1  rising-edge clock
- reset_n  in  1  asynchronous active-low reset
- start  in  1  begin one instruction; sampled only in IDLE
- mem_ready  in  1  memory read data valid in MDR path
- muldiv  in  1  op class is MUL/DIV (64-bit result to HI/LO); sampled on T2->T3
- ra, rb, rc  in  4 each  destination/source register indices; sampled on T2->T3
- bus_sel  out  SEL_W  mux select: 0 none, 1..16 R0..R15, 17 HI, 18 LO, 19 Zhigh, 20 Zlow, 21 PC, 22 MDR, 23 InPort, 24 C
- reg_in  out  16  one-hot register load
- pc_in, mar_in, mdr_in, ir_in, y_in, z_in, hi_in, lo_in  out  1 each  load strobes
- inc_pc, mem_read, alu_go  out  1 each  ALU PC-increment, memory read, ALU operate
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse on final step
- err  out  1  one-cycle pulse on memory timeout

Behaviour:
- States: IDLE, T0, T1, T2, T3, T4, T5, T6. All outputs are Moore-decoded from state and latched operands, except those noted for T1.
- Reset (async, reset_n low): state=IDLE, latched ra/rb/rc/muldiv=0, timeout counter=0, all outputs 0. Reset mid-instruction abandons it with no partial strobes after release.
- IDLE: all outputs 0. start=1 -> T0 next cycle.
- T0: bus_sel=21, mar_in=1, inc_pc=1, z_in=1 -> T1.
- T1: bus_sel=20, pc_in=1 on T1 entry cycle only, mem_read=1 every T1 cycle.
  - mdr_in=1 and exit to T2 in the cycle mem_ready=1.
  - Counter increments each T1 cycle with mem_ready=0. When it reaches MEM_TIMEOUT: err=1 pulse, -> IDLE.
  - Counter clears on T1 exit.
- T2: bus_sel=22, ir_in=1 -> T3. On this edge latch ra, rb, rc, muldiv.
- T3: bus_sel=1+rb, y_in=1 -> T4.
- T4: bus_sel=1+rc, alu_go=1, z_in=1 -> T5.
- T5, muldiv=0: bus_sel=20, reg_in[ra]=1, done=1 -> IDLE.
- T5, muldiv=1: bus_sel=20, lo_in=1 -> T6.
- T6: bus_sel=19, hi_in=1, done=1 -> IDLE.
- Latency: non-muldiv start to done = 6 cycles with mem_ready on first T1 cycle; +1 for muldiv; +N per wait cycle.
- start while busy is ignored (no queuing).
- reg_in is strictly one-hot or zero. At most one bus driver is selected per cycle.
- Latched operands are stable from T3 through the end of the instruction, regardless of input changes.

Decomposition:
- Shared package: state enum; BUS_SEL_* constants (NONE=0, R0_BASE=1, HI=17, LO=18, ZHI=19, ZLO=20, PC=21, MDR=22, INPORT=23, CSIGN=24).
- The bus mux uses the same BUS_SEL_* constants.
- One sub-module: reg_index_decoder (4-bit index + enable -> 16-bit one-hot), reused by the register file write port.

Test Plan:
- Reset mid-T4 (reset_n low 1 cycle) -> all outputs 0 immediately; state IDLE; no done pulse after release.
- start, mem_ready=1, ra=3, rb=5, rc=7, muldiv=0 -> bus_sel sequence 21,20,22,6,8,20; reg_in=0x0008 in T5; done on cycle 6.
- Same with muldiv=1 -> T5 bus_sel=20 with lo_in; T6 bus_sel=19 with hi_in and done; reg_in stays 0 throughout.
- mem_ready held low 3 cycles in T1 -> mem_read high 4 cycles; pc_in only on first T1 cycle; mdr_in only on 4th; done 3 cycles later than baseline.
- mem_ready never asserted, MEM_TIMEOUT=15 -> err pulse after 15 wait cycles; return to IDLE; done never asserted.
- start pulsed during T3; ra changed during T4 -> no restart; T5 writes the ra latched at T2->T3.
